// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, aluop
// instruction classes and the controller FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of instruction class / funct3 / funct7 bit 30 into a
// 4-bit ALU op, flagging every combination the ALU does not support.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    op = ALU_ADD;
      ALUOP_BRANCH: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case ({funct3, funct7b5})
          {3'b000, 1'b0}: op = ALU_ADD;
          {3'b000, 1'b1}: op = ALU_SUB;
          {3'b111, 1'b0}: op = ALU_AND;
          {3'b110, 1'b0}: op = ALU_OR;
          default:        illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one request, drives the external registered ALU
// for one cycle, captures its result and holds the response until taken.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  output logic             alu_enable,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and the response fields stay
  // stable while rsp_valid is high and rsp_ready is low.

  state_e             state_q, state_d;
  logic               alu_enable_q, alu_enable_d;
  logic [WIDTH-1:0]   alu_data1_q, alu_data1_d;
  logic [WIDTH-1:0]   alu_data2_q, alu_data2_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_illegal_q, rsp_illegal_d;

  logic [3:0]         dec_op;
  logic               dec_illegal;
  logic               accept;

  alu_op_decode u_decode (
    .aluop    (req_aluop),
    .funct3   (req_funct3),
    .funct7b5 (req_funct7b5),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d       = state_q;
    alu_enable_d  = 1'b0;
    alu_data1_d   = alu_data1_q;
    alu_data2_d   = alu_data2_q;
    alu_op_d      = alu_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_data1_d = req_rs1;
          alu_data2_d = req_rs2;
          alu_op_d    = dec_op;
          // Illegal ops skip the ALU entirely and answer with a zero result.
          if (dec_illegal) begin
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_result_d  = '0;
            rsp_zero_d    = 1'b0;
            rsp_illegal_d = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            alu_enable_d = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d       = ST_RESP;
        rsp_valid_d   = 1'b1;
        rsp_result_d  = alu_result;
        rsp_zero_d    = alu_zero;
        rsp_illegal_d = 1'b0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      alu_enable_q  <= 1'b0;
      alu_data1_q   <= '0;
      alu_data2_q   <= '0;
      alu_op_q      <= ALU_AND;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_enable_q  <= alu_enable_d;
      alu_data1_q   <= alu_data1_d;
      alu_data2_q   <= alu_data2_d;
      alu_op_q      <= alu_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign alu_enable  = alu_enable_q;
  assign alu_data1   = alu_data1_q;
  assign alu_data2   = alu_data2_q;
  assign alu_op      = alu_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl paired with a registered ALU: directed cases plus
// random requests, responses checked by a queue-based scoreboard.
module tb_alu_issue_ctrl;
  localparam int W = 64;

  logic         clock;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_aluop;
  logic [2:0]   req_funct3;
  logic         req_funct7b5;
  logic [W-1:0] req_rs1, req_rs2;
  logic         alu_enable;
  logic [W-1:0] alu_data1, alu_data2;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_illegal;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic force_low = 1'b0;
  logic [W+1:0] exp_q[$];

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .alu_enable(alu_enable), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ALU: result appears one edge after an enabled cycle.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
    end else if (alu_enable) begin
      case (alu_op)
        4'b0000: alu_result <= alu_data1 & alu_data2;
        4'b0001: alu_result <= alu_data1 | alu_data2;
        4'b0010: alu_result <= alu_data1 + alu_data2;
        4'b0110: alu_result <= alu_data1 - alu_data2;
        default: alu_result <= '0;
      endcase
      case (alu_op)
        4'b0000: alu_zero <= ((alu_data1 & alu_data2) == '0);
        4'b0001: alu_zero <= ((alu_data1 | alu_data2) == '0);
        4'b0010: alu_zero <= ((alu_data1 + alu_data2) == '0);
        4'b0110: alu_zero <= ((alu_data1 - alu_data2) == '0);
        default: alu_zero <= 1'b1;
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic logic is_illegal(input logic [1:0] c, input logic [2:0] f3, input logic b5);
    if (c == 2'b00 || c == 2'b01) return 1'b0;
    if (c == 2'b11) return 1'b1;
    if (f3 == 3'b000) return 1'b0;
    if ((f3 == 3'b111 || f3 == 3'b110) && !b5) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_op(input logic [1:0] c, input logic [2:0] f3, input logic b5);
    if (c == 2'b00) return 4'b0010;
    if (c == 2'b01) return 4'b0110;
    if (f3 == 3'b000) return b5 ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    return 4'b0001;
  endfunction

  // Expected response packed as {illegal, zero, result}.
  function automatic logic [W+1:0] model_rsp(input logic [1:0] c, input logic [2:0] f3,
                                             input logic b5, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    if (is_illegal(c, f3, b5)) return {1'b1, 1'b0, {W{1'b0}}};
    case (model_op(c, f3, b5))
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      default: r = a | b;
    endcase
    return {1'b0, (r == '0), r};
  endfunction

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_enable"}, W'(alu_enable), '0);
    check({tag, "_alu_data1"}, W'(alu_data1), '0);
    check({tag, "_alu_data2"}, W'(alu_data2), '0);
    check({tag, "_alu_op"}, W'(alu_op), '0);
    check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    check({tag, "_rsp"}, {rsp_illegal, rsp_zero, rsp_result}, '0);
    check({tag, "_req_ready"}, W'(req_ready), 1);
  endtask

  // ---------------- response ready driver ----------------
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2 rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_stall;
    logic [W+1:0] prev_rsp;
    logic [W+1:0] exp;
    prev_stall = 1'b0;
    prev_rsp   = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("rsp_hold_valid", W'(rsp_valid), 1);
          check("rsp_hold_data", {rsp_illegal, rsp_zero, rsp_result}, prev_rsp);
        end
        if (rsp_valid) begin
          check("req_ready_in_resp", W'(req_ready), 0);
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", {rsp_illegal, rsp_zero, rsp_result}, '1);
            end else begin
              exp = exp_q.pop_front();
              check("rsp", {rsp_illegal, rsp_zero, rsp_result}, exp);
            end
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_illegal, rsp_zero, rsp_result};
      end
    end
  end

  // ---------------- driver ----------------
  // Latency counts the accept edge as edge 1: legal responses show at 3,
  // illegal ones at 1.
  task automatic send(input logic [1:0] c, input logic [2:0] f3, input logic b5,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    int  waitc;
    int  lat;
    int  en_cnt;
    logic ill;
    ill   = is_illegal(c, f3, b5);
    waitc = 0;
    @(negedge clock);
    while (!req_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", W'(req_ready), 1);
      return;
    end
    req_valid = 1'b1; req_aluop = c; req_funct3 = f3; req_funct7b5 = b5;
    req_rs1 = a; req_rs2 = b;
    @(posedge clock);
    exp_q.push_back(model_rsp(c, f3, b5, a, b));
    #1;
    req_valid = 1'b0;
    req_rs1 = {$urandom, $urandom};
    req_rs2 = {$urandom, $urandom};
    lat = 0;
    en_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (alu_enable) en_cnt++;
      if (k == 1 && !ill) begin
        check("alu_op", W'(alu_op), W'(model_op(c, f3, b5)));
        check("alu_data1", W'(alu_data1), W'(a));
        check("alu_data2", W'(alu_data2), W'(b));
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", W'(lat), ill ? 1 : 3);
    check("enable_pulses", W'(en_cnt), ill ? 0 : 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    req_valid = 1'b0; req_aluop = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_rs1 = '0; req_rs2 = '0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    send(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
    send(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234);
    send(2'b10, 3'b001, 1'b0, 64'd9, 64'd3);
    send(2'b10, 3'b000, 1'b1, 64'd0, 64'd1);
    send(2'b11, 3'b000, 1'b0, 64'd1, 64'd1);
    send(2'b00, 3'b101, 1'b1, 64'h100, 64'h20);
    send(2'b10, 3'b110, 1'b0, 64'hF0, 64'h0F);

    // Backpressure on an AND: response must sit still for five cycles.
    force_low = 1'b1;
    @(posedge clock);
    #3;
    send(2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid", W'(rsp_valid), 1);
      check("bp_result", W'(rsp_result), 64'h30);
      check("bp_req_ready", W'(req_ready), 0);
    end
    force_low = 1'b0;

    // Reset while the op sits in CAPTURE: no response may appear for it.
    @(negedge clock);
    while (!req_ready) @(negedge clock);
    req_valid = 1'b1; req_aluop = 2'b10; req_funct3 = 3'b000; req_funct7b5 = 1'b0;
    req_rs1 = 64'd40; req_rs2 = 64'd2;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("no_rsp_after_reset", W'(rsp_valid), 0);
    end
    send(2'b10, 3'b000, 1'b0, 64'd40, 64'd2);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] c;
      logic [2:0] f3;
      logic       b5;
      logic [W-1:0] a, b;
      c  = 2'($urandom_range(0, 3));
      f3 = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) :
           (($urandom_range(0, 1) != 0) ? 3'b000 : 3'b111);
      b5 = ($urandom_range(0, 3) == 0);
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      send(c, f3, b5, a, b);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drained", W'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
